// File: rtl/instr_encoder.sv
// instr_encoder: RISC-V base-format instruction encoder with range checking, FIFO output buffer and saturating stats.
module instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       fmt_i,
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       func3_i,
  input  logic [6:0]       func7_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [31:0]      imm_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      instr_o,
  output logic             err_o,
  output logic [CNT_W-1:0] enc_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [32:0] mem_q [DEPTH];
  logic [32:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d, err_cnt_q, err_cnt_d;
  logic [31:0] enc;
  logic bad, push, pop, fit12, fit13, fit21;
  logic [32:0] entry;
  // An immediate fits N signed bits when every bit above N-2 equals the sign.
  always_comb begin
    fit12 = &imm_i[31:11] | ~|imm_i[31:11];
    fit13 = (&imm_i[31:12] | ~|imm_i[31:12]) & ~imm_i[0];
    fit21 = (&imm_i[31:20] | ~|imm_i[31:20]) & ~imm_i[0];
    enc = 32'h0000_0013;
    bad = 1'b1;
    case (fmt_i)
      3'd0: begin
        enc = {func7_i, rs2_i, rs1_i, func3_i, rd_i, opcode_i};
        bad = 1'b0;
      end
      3'd1: begin
        enc = {imm_i[11:0], rs1_i, func3_i, rd_i, opcode_i};
        bad = ~fit12;
      end
      3'd2: begin
        enc = {imm_i[11:5], rs2_i, rs1_i, func3_i, imm_i[4:0], opcode_i};
        bad = ~fit12;
      end
      3'd3: begin
        enc = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, func3_i, imm_i[4:1], imm_i[11], opcode_i};
        bad = ~fit13;
      end
      3'd4: begin
        enc = {imm_i[31:12], rd_i, opcode_i};
        bad = |imm_i[11:0];
      end
      3'd5: begin
        enc = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        bad = ~fit21;
      end
      default: bad = 1'b1;
    endcase
    entry = {bad, bad ? 32'h0000_0013 : enc};
  end
  assign in_ready_o  = count_q < CW'(DEPTH);
  assign out_valid_o = count_q != '0;
  assign {err_o, instr_o} = mem_q[rd_ptr_q];
  assign enc_cnt_o = enc_cnt_q;
  assign err_cnt_o = err_cnt_q;
  always_comb begin
    push = in_valid_i & in_ready_o;
    pop = out_valid_o & out_ready_i;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = entry;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    enc_cnt_d = (push && !(&enc_cnt_q)) ? enc_cnt_q + CNT_W'(1) : enc_cnt_q;
    err_cnt_d = (push && bad && !(&err_cnt_q)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized scenario bench for instr_encoder against an arithmetic reference model and queue scoreboard.
module tb_instr_encoder;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk_i = 1'b0;
  logic rst_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, err_o;
  logic [2:0] fmt_i, func3_i;
  logic [6:0] opcode_i, func7_i;
  logic [4:0] rd_i, rs1_i, rs2_i;
  logic [31:0] imm_i, instr_o;
  logic [CNT_W-1:0] enc_cnt_o, err_cnt_o;
  int vectors = 0;
  int miscompares = 0;
  logic [32:0] exp_q [$];
  int enc_m = 0;
  int err_m = 0;
  int bnd [12] = '{-4097, -4096, -2049, -2048, 2047, 2048, 4094, 4095, -1048577, -1048576, 1048574, 1048576};

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .fmt_i(fmt_i), .opcode_i(opcode_i), .func3_i(func3_i), .func7_i(func7_i),
    .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .instr_o(instr_o), .err_o(err_o),
    .enc_cnt_o(enc_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [32:0] model(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    int s;
    logic [31:0] w, o, r1, r2, d, t3, t7, base;
    logic bad;
    s = imm;
    o = {25'd0, op};
    t3 = {29'd0, f3};
    t7 = {25'd0, f7};
    d = {27'd0, rd};
    r1 = {27'd0, rs1};
    r2 = {27'd0, rs2};
    base = (r1 << 15) | (t3 << 12) | o;
    bad = 1'b0;
    w = 32'd0;
    case (f)
      3'd0: w = (t7 << 25) | (r2 << 20) | base | (d << 7);
      3'd1: begin
        bad = s < -2048 || s > 2047;
        w = ((imm & 32'hfff) << 20) | base | (d << 7);
      end
      3'd2: begin
        bad = s < -2048 || s > 2047;
        w = (((imm >> 5) & 32'h7f) << 25) | (r2 << 20) | base | ((imm & 32'h1f) << 7);
      end
      3'd3: begin
        bad = s < -4096 || s > 4094 || (s % 2) != 0;
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (r2 << 20) | base |
            (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 32'h1) << 7);
      end
      3'd4: begin
        bad = (imm & 32'hfff) != 0;
        w = (imm & 32'hfffff000) | (d << 7) | o;
      end
      3'd5: begin
        bad = s < -1048576 || s > 1048574 || (s % 2) != 0;
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3ff) << 21) | (((imm >> 11) & 32'h1) << 20) |
            (((imm >> 12) & 32'hff) << 12) | (d << 7) | o;
      end
      default: bad = 1'b1;
    endcase
    return {bad, bad ? 32'h0000_0013 : w};
  endfunction

  // Advance one clock; handshakes are decided by the model's own occupancy.
  task automatic cycle(output logic popped, output logic pushed, output logic [32:0] got, output logic [32:0] exp);
    logic [32:0] e;
    int sz;
    sz = exp_q.size();
    popped = !rst_i && out_ready_i && sz != 0;
    pushed = !rst_i && in_valid_i && sz < DEPTH;
    got = {err_o, instr_o};
    exp = 'x;
    if (rst_i) begin
      exp_q.delete();
      enc_m = 0;
      err_m = 0;
    end else begin
      if (popped) exp = exp_q.pop_front();
      if (pushed) begin
        e = model(fmt_i, opcode_i, func3_i, func7_i, rd_i, rs1_i, rs2_i, imm_i);
        exp_q.push_back(e);
        enc_m = enc_m == CMAX ? CMAX : enc_m + 1;
        if (e[32]) err_m = err_m == CMAX ? CMAX : err_m + 1;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    fmt_i = f; opcode_i = op; func3_i = f3; func7_i = f7;
    rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
  endtask

  task automatic rand_req();
    logic [31:0] imm;
    case ($urandom_range(0, 3))
      0: imm = $urandom;
      1: imm = int'($urandom_range(0, 8191)) - 4096;
      2: imm = bnd[$urandom_range(0, 11)];
      default: imm = $urandom & 32'hfffff000;
    endcase
    set_req(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 7'($urandom),
            5'($urandom), 5'($urandom), 5'($urandom), imm);
  endtask

  task automatic test_reset();
    logic p, q;
    logic [32:0] g, e;
    rst_i = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b1;
    rand_req();
    cycle(p, q, g, e);
    cycle(p, q, g, e);
    rst_i = 1'b0; in_valid_i = 1'b0;
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_o); end
    vectors++; if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_o); end
    vectors++; if (instr_o !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h expected 0", instr_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err_o); end
    vectors++; if (enc_cnt_o !== '0) begin miscompares++; $display("FAIL reset_enc_cnt: got %0d expected 0", enc_cnt_o); end
    vectors++; if (err_cnt_o !== '0) begin miscompares++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt_o); end
  endtask

  task automatic test_known();
    logic p, q;
    logic [32:0] g, e;
    logic [32:0] want [3];
    want = '{{1'b0, 32'h00500093}, {1'b0, 32'h00208463}, {1'b0, 32'h001000EF}};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) set_req(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
      else if (i == 1) set_req(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
      else set_req(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
      in_valid_i = 1'b1; out_ready_i = 1'b0;
      cycle(p, q, g, e);
      in_valid_i = 1'b0;
      vectors++; if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL known_latency[%0d]: got %b expected 1", i, out_valid_o); end
      vectors++; if ({err_o, instr_o} !== want[i]) begin miscompares++; $display("FAIL known_word[%0d]: got %h expected %h", i, {err_o, instr_o}, want[i]); end
      out_ready_i = 1'b1;
      cycle(p, q, g, e);
      vectors++; if (!p || g !== e) begin miscompares++; $display("FAIL known_pop[%0d]: got %h expected %h", i, g, e); end
      out_ready_i = 1'b0;
    end
  endtask

  task automatic test_errors();
    logic p, q;
    logic [32:0] g, e;
    int pops = 0;
    rst_i = 1'b1;
    cycle(p, q, g, e);
    rst_i = 1'b0; out_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid_i = c < 3;
      if (c == 0) set_req(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd2048);
      else if (c == 1) set_req(3'd3, 7'b1100011, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
      else if (c == 2) set_req(3'd6, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
      cycle(p, q, g, e);
      if (p) begin
        pops++;
        vectors++; if (g !== {1'b1, 32'h0000_0013}) begin miscompares++; $display("FAIL err_entry[%0d]: got %h expected 100000013", pops, g); end
      end
    end
    vectors++; if (pops != 3) begin miscompares++; $display("FAIL err_pops: got %0d expected 3", pops); end
    vectors++; if (err_cnt_o !== 16'd3) begin miscompares++; $display("FAIL err_cnt: got %0d expected 3", err_cnt_o); end
    vectors++; if (enc_cnt_o !== 16'd3) begin miscompares++; $display("FAIL err_enc_cnt: got %0d expected 3", enc_cnt_o); end
  endtask

  task automatic test_full();
    logic p, q;
    logic [32:0] g, e, head;
    int pops = 0;
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    rand_req();
    cycle(p, q, g, e);
    rand_req();
    cycle(p, q, g, e);
    vectors++; if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b expected 0", in_ready_o); end
    head = {err_o, instr_o};
    rand_req();
    cycle(p, q, g, e);
    vectors++; if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin miscompares++; $display("FAIL full_hold: got ready %b valid %b expected 0 1", in_ready_o, out_valid_o); end
    vectors++; if ({err_o, instr_o} !== head) begin miscompares++; $display("FAIL full_stable: got %h expected %h", {err_o, instr_o}, head); end
    out_ready_i = 1'b1;
    for (int c = 0; c < 10 && pops < 3; c++) begin
      cycle(p, q, g, e);
      if (q) in_valid_i = 1'b0;
      if (p) begin
        pops++;
        vectors++; if (g !== e) begin miscompares++; $display("FAIL full_order[%0d]: got %h expected %h", pops, g, e); end
      end
    end
    in_valid_i = 1'b0;
    vectors++; if (pops != 3) begin miscompares++; $display("FAIL full_drain: got %0d expected 3", pops); end
  endtask

  task automatic test_back_to_back();
    logic p, q;
    logic [32:0] g, e;
    out_ready_i = 1'b1; in_valid_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      rand_req();
      if (c > 0) begin
        vectors++; if (out_valid_o !== 1'b1 || in_ready_o !== 1'b1) begin miscompares++; $display("FAIL b2b_flow[%0d]: got valid %b ready %b expected 1 1", c, out_valid_o, in_ready_o); end
      end
      cycle(p, q, g, e);
      if (p) begin
        vectors++; if (g !== e) begin miscompares++; $display("FAIL b2b_word[%0d]: got %h expected %h", c, g, e); end
      end
    end
    rst_i = 1'b1;
    rand_req();
    cycle(p, q, g, e);
    rst_i = 1'b0; in_valid_i = 1'b0;
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL b2b_rst_valid: got %b expected 0", out_valid_o); end
    vectors++; if (enc_cnt_o !== '0 || err_cnt_o !== '0) begin miscompares++; $display("FAIL b2b_rst_cnt: got %0d %0d expected 0 0", enc_cnt_o, err_cnt_o); end
    cycle(p, q, g, e);
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL b2b_stale: got %b expected 0", out_valid_o); end
  endtask

  task automatic test_random();
    logic p, q;
    logic [32:0] g, e;
    for (int c = 0; c < 400; c++) begin
      in_valid_i = 1'($urandom);
      out_ready_i = ($urandom_range(0, 3) != 0);
      rand_req();
      vectors++; if (out_valid_o !== (exp_q.size() != 0) || in_ready_o !== (exp_q.size() < DEPTH)) begin
        miscompares++; $display("FAIL rnd_flags[%0d]: got valid %b ready %b expected occupancy %0d", c, out_valid_o, in_ready_o, exp_q.size());
      end
      cycle(p, q, g, e);
      if (p) begin
        vectors++; if (g !== e) begin miscompares++; $display("FAIL rnd_word[%0d]: got %h expected %h", c, g, e); end
      end
      vectors++; if (enc_cnt_o !== CNT_W'(enc_m) || err_cnt_o !== CNT_W'(err_m)) begin
        miscompares++; $display("FAIL rnd_cnt[%0d]: got %0d %0d expected %0d %0d", c, enc_cnt_o, err_cnt_o, enc_m, err_m);
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic test_saturation();
    logic p, q;
    logic [32:0] g, e;
    int acc = 0;
    rst_i = 1'b1;
    cycle(p, q, g, e);
    rst_i = 1'b0; out_ready_i = 1'b1; in_valid_i = 1'b1;
    set_req(3'd6, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    for (int c = 0; c < 70000 && acc < CMAX + 6; c++) begin
      cycle(p, q, g, e);
      if (q) acc++;
    end
    in_valid_i = 1'b0;
    vectors++; if (acc != CMAX + 6) begin miscompares++; $display("FAIL sat_budget: got %0d expected %0d", acc, CMAX + 6); end
    vectors++; if (enc_cnt_o !== 16'hffff) begin miscompares++; $display("FAIL sat_enc: got %h expected ffff", enc_cnt_o); end
    vectors++; if (err_cnt_o !== 16'hffff) begin miscompares++; $display("FAIL sat_err: got %h expected ffff", err_cnt_o); end
  endtask

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    set_req(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    test_reset();
    test_known();
    test_errors();
    test_full();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 2, output buffer entries (power of two, >= 2).
REQ-002 Parameter CNT_W, default 16, width of statistic counters.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 in_valid_i  in  1  request valid.
REQ-006 in_ready_o  out  1  request accepted when in_valid_i && in_ready_o.
REQ-007 fmt_i  in  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6-7 illegal.
REQ-008 opcode_i  in  7  opcode field, placed in bits [6:0] unchanged.
REQ-009 func3_i  in  3  func3 field, used by R/I/S/B.
REQ-010 func7_i  in  7  func7 field, used by R only.
REQ-011 rd_i, rs1_i, rs2_i  in  5 each  register indices.
REQ-012 imm_i  in  32  signed immediate byte value (U: full value, low 12 bits must be zero).
REQ-013 out_valid_o  out  1  encoded word valid.
REQ-014 out_ready_i  in  1  consumer ready; transfer when out_valid_o && out_ready_i.
REQ-015 instr_o  out  32  encoded instruction word.
REQ-016 err_o  out  1  entry was illegal format or immediate out of range.
REQ-017 enc_cnt_o, err_cnt_o  out  CNT_W each  accepted requests / errored requests.

Function
REQ-018 Encoding per RISC-V base formats: R {func7,rs2,rs1,func3,rd,opcode}; I {imm[11:0],rs1,func3,rd,opcode}; S {imm[11:5],rs2,rs1,func3,imm[4:0],opcode}; B {imm[12],imm[10:5],rs2,rs1,func3,imm[4:1],imm[11],opcode}; U {imm[31:12],rd,opcode}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-019 Range checks: I/S imm in [-2048,2047]; B imm in [-4096,4094] and imm[0]=0; J imm in [-1048576,1048574] and imm[0]=0; U imm[11:0]=0; R ignores imm_i.
REQ-020 Illegal fmt or failed range check: entry stored with instr_o=32'h0000_0013 (NOP) and err_o=1.
REQ-021 Encoding computed combinationally from inputs and written into the FIFO on acceptance; latency accept-to-out_valid_o = 1 cycle when buffer empty.
REQ-022 Output buffer: in-order FIFO of DEPTH entries {instr,err}; instr_o/err_o/out_valid_o driven from head entry.
REQ-023 in_ready_o = (count < DEPTH); no combinational path from out_ready_i to in_ready_o.
REQ-024 Full: in_ready_o=0, in_valid_i ignored; simultaneous pop frees space visible next cycle.
REQ-025 Empty: out_valid_o=0; instr_o/err_o hold last value, not checked by consumer.
REQ-026 Simultaneous push and pop with count in (0,DEPTH): count unchanged, both pointers advance.
REQ-027 Pointers wrap modulo DEPTH; entry order preserved across wrap.
REQ-028 out_valid_o, once high, stays high with stable instr_o/err_o until transferred.
REQ-029 enc_cnt_o increments on every acceptance; err_cnt_o increments on accepted errored entry; both saturate at 2^CNT_W-1.

Reset
REQ-030 While rst_i=1 at clock edge: count=0, pointers=0, out_valid_o=0, in_ready_o=1 after the edge, instr_o=0, err_o=0, enc_cnt_o=0, err_cnt_o=0.
REQ-031 Reset mid-operation discards all buffered entries; no output transfer occurs in the reset cycle; requests presented during reset are not accepted.

Verification
REQ-032 I fmt, opcode 0010011, func3 0, rd 1, rs1 0, imm 5 -> instr_o=0x00500093, err_o=0, out_valid_o one cycle after accept.
REQ-033 B fmt, opcode 1100011, func3 0, rs1 1, rs2 2, imm 8 -> 0x00208463; J fmt, opcode 1101111, rd 1, imm 2048 -> 0x001000EF.
REQ-034 I fmt imm 2048, then B imm 3, then fmt 6 -> three entries instr_o=0x00000013, err_o=1, err_cnt_o=3, enc_cnt_o=3.
REQ-035 out_ready_i=0, push 3 requests (DEPTH=2) -> in_ready_o=0 after second, third held; raise out_ready_i -> three words emerge in order, pointers wrap correctly.
REQ-036 Continuous push/pop with out_ready_i=1 for 10 cycles -> one word per cycle, count constant; assert rst_i mid-stream -> out_valid_o=0, counters 0 next cycle, no stale word after reset.
REQ-037 Drive 2^CNT_W+5 accepted requests -> enc_cnt_o saturates at 2^CNT_W-1.
